// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the fetch/decode slice of the CPU:
//   - default address and data widths of the single-port instruction/data RAM
//   - instruction opcode encoding and field positions
//   - fetch FSM state encoding
//   - small helpers that slice instruction fields out of a word
package cpu_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

  // Instruction field positions
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RX_HI  = 9;
  localparam int RX_LO  = 5;
  localparam int RY_HI  = 4;
  localparam int RY_LO  = 0;

  typedef enum logic [4:0] {
    OP_MV  = 5'd0,
    OP_MVI = 5'd1,
    OP_ADD = 5'd2,
    OP_SUB = 5'd3,
    OP_LD  = 5'd4,
    OP_ST  = 5'd5,
    OP_AND = 5'd6,
    OP_OR  = 5'd7,
    OP_XOR = 5'd8,
    OP_NOT = 5'd9
  } opcode_t;

  typedef enum logic [2:0] {
    ISSUE     = 3'd0,
    CAP       = 3'd1,
    ISSUE_IMM = 3'd2,
    CAP_IMM   = 3'd3,
    HOLD      = 3'd4
  } fetch_state_t;

  function automatic logic [4:0] get_opcode(input logic [DEF_DATA_W-1:0] word);
    return word[OPC_HI:OPC_LO];
  endfunction

  function automatic logic [4:0] get_rx(input logic [DEF_DATA_W-1:0] word);
    return word[RX_HI:RX_LO];
  endfunction

  function automatic logic [4:0] get_ry(input logic [DEF_DATA_W-1:0] word);
    return word[RY_HI:RY_LO];
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch sequencer and arbiter for the single RAM port. Fetches
// the instruction word at pc (plus the immediate word that follows an mvi),
// presents the complete instruction downstream over valid/ready, and lets
// the decode/execute stage's ld/st accesses share the port.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ram_wr_en/address/data_in  RAM command (combinational from state + request)
//   ram_data_out               RAM read data, one cycle after the address
//   instr_valid/instr_ready    downstream handshake
//   instr, imm, instr_pc       captured instruction, immediate (0 if none), address
//   dmem_req/we/addr/wdata     data access request from execute
//   dmem_gnt                   request accepted this cycle
//   dmem_rvalid/dmem_rdata     load data, one cycle after a load grant
module fetch_unit #(
  parameter int                ADDR_W   = cpu_pkg::DEF_ADDR_W,
  parameter int                DATA_W   = cpu_pkg::DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [4:0]        OPC_MVI  = 5'b00001
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] imm,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              dmem_req,
  input  logic              dmem_we,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_gnt,
  output logic              dmem_rvalid,
  output logic [DATA_W-1:0] dmem_rdata
);

  import cpu_pkg::*;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              valid_q, valid_d;
  logic              rvalid_q, rvalid_d;

  logic              gnt_s;
  logic              ram_wr_en_s;
  logic [ADDR_W-1:0] ram_address_s;
  logic [DATA_W-1:0] ram_data_in_s;

  // Port arbitration: a data request wins the port in ISSUE and HOLD;
  // otherwise the port reads at pc (a harmless read outside fetch states).
  always_comb begin
    gnt_s = dmem_req & ((state_q == ISSUE) | (state_q == HOLD));
    if (gnt_s) begin
      ram_address_s = dmem_addr;
      ram_wr_en_s   = dmem_we;
      ram_data_in_s = dmem_wdata;
    end else begin
      ram_address_s = pc_q;
      ram_wr_en_s   = 1'b0;
      ram_data_in_s = '0;
    end
  end

  // Fetch sequencing and instruction capture.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    ipc_d   = ipc_q;
    case (state_q)
      ISSUE: begin
        // A pending data request starves fetch until it drops.
        if (dmem_req) begin
          state_d = ISSUE;
        end else begin
          state_d = CAP;
        end
      end
      CAP: begin
        ir_d  = ram_data_out;
        ipc_d = pc_q;
        pc_d  = pc_q + PC_ONE;
        if (get_opcode(ram_data_out) == OPC_MVI) begin
          state_d = ISSUE_IMM;
        end else begin
          imm_d   = '0;
          state_d = HOLD;
        end
      end
      ISSUE_IMM: begin
        state_d = CAP_IMM;
      end
      CAP_IMM: begin
        imm_d   = ram_data_out;
        pc_d    = pc_q + PC_ONE;
        state_d = HOLD;
      end
      HOLD: begin
        // A grant in this same cycle is independent of the handshake.
        if (instr_ready) begin
          state_d = ISSUE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = ISSUE;
      end
    endcase
    // instr_valid is registered so it tracks HOLD without a decode on the output.
    valid_d  = (state_d == HOLD);
    rvalid_d = gnt_s & ~dmem_we;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ISSUE;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      imm_q    <= '0;
      ipc_q    <= '0;
      valid_q  <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      imm_q    <= imm_d;
      ipc_q    <= ipc_d;
      valid_q  <= valid_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign ram_wr_en   = ram_wr_en_s;
  assign ram_address = ram_address_s;
  assign ram_data_in = ram_data_in_s;
  assign dmem_gnt    = gnt_s;

  assign instr_valid = valid_q;
  assign instr       = ir_q;
  assign imm         = imm_q;
  assign instr_pc    = ipc_q;
  assign dmem_rvalid = rvalid_q;
  // The RAM output register is the data register; gate it so rdata is 0 when idle.
  assign dmem_rdata  = rvalid_q ? ram_data_out : '0;

endmodule
